// File: rtl/memtest_pkg.sv
// Shared definitions for the memory-tester answer checker.
package memtest_pkg;

  localparam int unsigned DEPTH = 7;
  localparam int unsigned DW    = 4;
  localparam logic [3:0]  ECHO_RST = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    INPUT   = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/seq_buffer.sv
// Ordered digit store: one write port, asynchronous read, no reset on storage.
module seq_buffer #(
  parameter int unsigned DEPTH = 7,
  parameter int unsigned DW    = 4,
  parameter int unsigned AW    = 3
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Store the captured digit at the requested slot.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/answer_checker.sv
// Captures the flashed sequence, then checks keypad entries against it in order.
module answer_checker #(
  parameter int unsigned DEPTH = memtest_pkg::DEPTH,
  parameter int unsigned DW    = memtest_pkg::DW
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          seq_shl,
  input  logic [DW-1:0] seq_digit,
  input  logic          begin_timer,
  input  logic          time_stop,
  input  logic          logout,
  input  logic          key_valid,
  input  logic [DW-1:0] key_code,
  output logic          win,
  output logic          loose,
  output logic [2:0]    seq_len,
  output logic [2:0]    entered_count,
  output logic [DW-1:0] echo_digit,
  output logic          overflow,
  output logic          busy
);

  import memtest_pkg::*;

  state_e        state_q, state_d;
  logic [2:0]    seq_len_q, seq_len_d;
  logic [2:0]    entered_q, entered_d;
  logic [DW-1:0] echo_q, echo_d;
  logic          overflow_q, overflow_d;
  logic          win_q, win_d;
  logic          loose_q, loose_d;
  logic          busy_q;

  logic          buf_we;
  logic [2:0]    buf_waddr;
  logic [DW-1:0] buf_rdata;

  seq_buffer #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (3)
  ) u_buf (
    .clock (clock),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (seq_digit),
    .raddr (entered_q),
    .rdata (buf_rdata)
  );

  // Next-state, counter updates and buffer write control.
  always_comb begin
    state_d    = state_q;
    seq_len_d  = seq_len_q;
    entered_d  = entered_q;
    echo_d     = echo_q;
    overflow_d = overflow_q;
    win_d      = 1'b0;
    loose_d    = 1'b0;
    buf_we     = 1'b0;
    buf_waddr  = '0;

    if (logout) begin
      state_d   = IDLE;
      seq_len_d = '0;
      entered_d = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (seq_shl) begin
            buf_we     = 1'b1;
            buf_waddr  = '0;
            seq_len_d  = 3'd1;
            entered_d  = '0;
            overflow_d = 1'b0;
            state_d    = CAPTURE;
          end
        end
        CAPTURE: begin
          if (seq_shl) begin
            if (seq_len_q < 3'(DEPTH)) begin
              buf_we    = 1'b1;
              buf_waddr = seq_len_q;
              seq_len_d = seq_len_q + 3'd1;
            end else begin
              overflow_d = 1'b1;
            end
          end
          if (begin_timer) begin
            entered_d = '0;
            state_d   = INPUT;
          end
        end
        INPUT: begin
          // Timeout outranks any same-cycle key, even a completing one.
          if (time_stop) begin
            loose_d = 1'b1;
            state_d = DONE;
          end else if (key_valid) begin
            echo_d = key_code;
            if (key_code == buf_rdata) begin
              entered_d = entered_q + 3'd1;
              if (entered_q + 3'd1 == seq_len_q) begin
                win_d   = 1'b1;
                state_d = DONE;
              end
            end else begin
              loose_d = 1'b1;
              state_d = DONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q    <= IDLE;
      seq_len_q  <= '0;
      entered_q  <= '0;
      echo_q     <= DW'(ECHO_RST);
      overflow_q <= 1'b0;
      win_q      <= 1'b0;
      loose_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_len_q  <= seq_len_d;
      entered_q  <= entered_d;
      echo_q     <= echo_d;
      overflow_q <= overflow_d;
      win_q      <= win_d;
      loose_q    <= loose_d;
      busy_q     <= (state_d == INPUT);
    end
  end

  assign win           = win_q;
  assign loose         = loose_q;
  assign seq_len       = seq_len_q;
  assign entered_count = entered_q;
  assign echo_digit    = echo_q;
  assign overflow      = overflow_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_answer_checker.sv
// Scoreboard bench for answer_checker: expected win/loose pulses are queued by
// the stimulus, a negedge monitor pops and compares whenever a pulse appears.
module tb_answer_checker;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       seq_shl = 1'b0;
  logic [3:0] seq_digit = '0;
  logic       begin_timer = 1'b0;
  logic       time_stop = 1'b0;
  logic       logout = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = '0;
  logic       win, loose, overflow, busy;
  logic [2:0] seq_len, entered_count;
  logic [3:0] echo_digit;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  bit exp_q[$];  // 1 = win expected, 0 = loose expected

  answer_checker #(.DEPTH(7), .DW(4)) dut (
    .clock         (clock),
    .rst           (rst),
    .seq_shl       (seq_shl),
    .seq_digit     (seq_digit),
    .begin_timer   (begin_timer),
    .time_stop     (time_stop),
    .logout        (logout),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .win           (win),
    .loose         (loose),
    .seq_len       (seq_len),
    .entered_count (entered_count),
    .echo_digit    (echo_digit),
    .overflow      (overflow),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: every win/loose sample must match the head of the queue.
  always @(negedge clock) begin
    if (rst && (win || loose)) begin
      if (exp_q.size() == 0) begin
        check("spurious_pulse", {30'd0, win, loose}, 0);
      end else begin
        bit e;
        e = exp_q.pop_front();
        check("pulse_kind", {30'd0, win, loose}, e ? 2 : 1);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic shl(input logic [3:0] d);
    seq_shl = 1'b1; seq_digit = d;
    tick();
    seq_shl = 1'b0;
  endtask

  task automatic start();
    begin_timer = 1'b1;
    tick();
    begin_timer = 1'b0;
  endtask

  task automatic key(input logic [3:0] k);
    key_valid = 1'b1; key_code = k;
    tick();
    key_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    rst = 1'b0;
    tick(); tick();
    check("rst_seq_len", seq_len, 0);
    check("rst_entered", entered_count, 0);
    check("rst_echo", echo_digit, 15);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {win, loose}, 0);
    rst = 1'b1;
    tick();

    // Full match 3,7,1 with back-to-back keys
    shl(4'd3); check("t1_len1", seq_len, 1);
    shl(4'd7); shl(4'd1);
    check("t1_len", seq_len, 3);
    check("t1_busy_pre", busy, 0);
    start();
    check("t1_busy", busy, 1);
    key(4'd3); key(4'd7);
    check("t1_entered2", entered_count, 2);
    exp_q.push_back(1'b1);
    key(4'd1);
    check("t1_entered3", entered_count, 3);
    check("t1_busy_done", busy, 0);
    tick();
    check("t1_win_gone", win, 0);

    // Mismatch on third key
    shl(4'd5); shl(4'd5); shl(4'd2); shl(4'd9);
    check("t2_len", seq_len, 4);
    start();
    check("t2_entered0", entered_count, 0);
    key(4'd5); key(4'd5);
    exp_q.push_back(1'b0);
    key(4'd8);
    check("t2_entered", entered_count, 2);
    check("t2_echo", echo_digit, 8);
    tick();

    // Timeout after two correct keys
    shl(4'd1); shl(4'd2); shl(4'd3); shl(4'd4);
    start();
    key(4'd1); key(4'd2);
    exp_q.push_back(1'b0);
    time_stop = 1'b1; tick(); time_stop = 1'b0;
    check("t3a_entered", entered_count, 2);
    check("t3a_busy", busy, 0);
    tick();

    // Timeout coincident with the completing key: loose wins the race
    shl(4'd1); shl(4'd2); shl(4'd3); shl(4'd4);
    start();
    key(4'd1); key(4'd2); key(4'd3);
    exp_q.push_back(1'b0);
    time_stop = 1'b1; key_valid = 1'b1; key_code = 4'd4;
    tick();
    time_stop = 1'b0; key_valid = 1'b0;
    check("t3b_entered", entered_count, 3);
    check("t3b_echo", echo_digit, 3);
    tick();

    // Overflow: eight strobes into a seven-deep buffer
    for (int i = 0; i < 8; i++) shl(4'(i));
    check("t4_len", seq_len, 7);
    check("t4_overflow", overflow, 1);
    start();
    for (int i = 0; i < 6; i++) key(4'(i));
    check("t4_entered6", entered_count, 6);
    exp_q.push_back(1'b1);
    key(4'd6);
    check("t4_entered7", entered_count, 7);
    tick();

    // Logout mid-INPUT; later keys and an idle begin_timer are ignored
    shl(4'd2);
    check("t5_overflow_clr", overflow, 0);
    shl(4'd4);
    start();
    key(4'd2);
    logout = 1'b1; tick(); logout = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_len", seq_len, 0);
    check("t5_entered", entered_count, 0);
    key(4'd4);
    check("t5_echo_kept", echo_digit, 2);
    check("t5_entered_kept", entered_count, 0);
    start();
    check("t5_idle_begin", busy, 0);
    tick();

    // Reset during INPUT, then a one-digit round
    shl(4'd6); shl(4'd1);
    start();
    rst = 1'b0; tick(); rst = 1'b1;
    check("t6_busy", busy, 0);
    check("t6_len", seq_len, 0);
    check("t6_echo", echo_digit, 15);
    check("t6_entered", entered_count, 0);
    shl(4'd9);
    start();
    exp_q.push_back(1'b1);
    key(4'd9);
    check("t6_entered1", entered_count, 1);

    // Drain: every queued pulse must have been seen within a few cycles
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) tick();
    tick();
    check("pending_pulses", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/answer_checker.md
# answer_checker

Downstream stage of the sequence flasher in the memory-tester game. Captures each digit flashed to the player (strobed by the flasher's `shl` pulse with `flash_num[3:0]`) into a small ordered buffer. After the timer starts, it compares the player's keypad entries against that buffer in order. It raises single-cycle `win`/`loose` pulses that the flasher's timer state consumes to halt the round.

## Interface
Parameters:
- DEPTH, 7, maximum stored sequence length (level 5 flashes 7 digits)
- DW, 4, digit width

Ports:
- clock  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- seq_shl  in  1  one-cycle capture strobe from flasher
- seq_digit  in  DW  digit to capture when `seq_shl`=1
- begin_timer  in  1  one-cycle pulse; end of flashing, start of entry phase
- time_stop  in  1  entry timer expired
- logout  in  1  abort round
- key_valid  in  1  one-cycle strobe, debounced keypad entry
- key_code  in  DW  entered digit
- win  out  1  one-cycle pulse, full sequence matched
- loose  out  1  one-cycle pulse, mismatch or timeout
- seq_len  out  3  digits captured this round
- entered_count  out  3  correct digits entered so far
- echo_digit  out  DW  last accepted key, for display
- overflow  out  1  sticky; a strobe arrived while buffer full
- busy  out  1  high in INPUT state

## Operation
States: IDLE, CAPTURE, INPUT, DONE.
- Reset (rst=0 at clock edge): state IDLE, win=0, loose=0, seq_len=0, entered_count=0, echo_digit=4'hF, overflow=0, busy=0. Buffer contents are don't-care.
- IDLE or DONE, `seq_shl`=1: buf[0]<=seq_digit, seq_len<=1, entered_count<=0, overflow<=0, go CAPTURE.
- CAPTURE, `seq_shl`=1: if seq_len<DEPTH then buf[seq_len]<=seq_digit and seq_len++. Else overflow<=1 and the digit is dropped.
- CAPTURE, `begin_timer`=1: go INPUT, entered_count<=0. If `seq_shl` and `begin_timer` arrive in the same cycle, the digit is stored first, then the state moves to INPUT.
- IDLE, `begin_timer`=1 (zero-length round): ignored. The round is ended by the flasher's `time_stop`/logout.
- INPUT, `key_valid`=1:
  - echo_digit<=key_code.
  - If key_code==buf[entered_count]: entered_count++. If that was index seq_len-1, pulse win and go DONE.
  - On mismatch: pulse loose and go DONE.
- INPUT, `time_stop`=1: pulse loose and go DONE. This has priority over a same-cycle `key_valid`, including a completing match.
- `logout`=1 in any state: go IDLE, win=loose=0, entered_count=0, seq_len=0. This has highest priority.
- Inputs outside their states are ignored:
  - `key_valid` outside INPUT (echo_digit unchanged).
  - `seq_shl` in INPUT.
  - `time_stop` outside INPUT.
- DONE holds seq_len and entered_count for display until the next `seq_shl` or `logout`.
- All compares are a full DW-bit equality with no digit-range filtering. Counters are 3 bits and never wrap, because they are bounded by DEPTH.

## Timing
- All outputs are registered.
- A captured digit is readable in the cycle after `seq_shl`.
- win/loose assert in the cycle after the deciding `key_valid`/`time_stop` edge and stay high exactly one cycle.
- `busy` rises in the cycle after `begin_timer`.
- Back-to-back `key_valid` on consecutive cycles is supported, with one compare per cycle.
- win and loose are never high together.

## Structure
- Shared package `memtest_pkg`: state enum {IDLE, CAPTURE, INPUT, DONE}, DEPTH, DW, reset echo value 4'hF.
- Sub-module `seq_buffer`: DEPTH×DW register file with a write port (we, waddr, wdata) and an asynchronous read port (raddr → rdata), no reset on the storage. The FSM and counters live in `answer_checker`.

## Test plan
- Capture 3,7,1 then begin_timer; keys 3,7,1 → win pulse 1 cycle after third key, entered_count=3, loose never high.
- Capture 5,5,2,9; keys 5,5,8 → loose pulse after third key, entered_count=2, echo_digit=8.
- Capture 4 digits, enter 2 correct, time_stop high → loose pulse next cycle. Repeat with time_stop coincident with the completing fourth key → loose, not win.
- Eight seq_shl strobes (0..7) → seq_len=7, overflow=1. Keys 0..6 → win.
- logout mid-INPUT after 1 correct key → next cycle IDLE, busy=0, seq_len=0, no pulse. Subsequent key_valid ignored.
- rst=0 during INPUT → all outputs at reset values next cycle. New capture of 1 digit plus a matching key → win.
